// File: rtl/pe_pair_feeder_pkg.sv
// Shared FFT datapath types plus the pair-feeder FSM state encoding.
`ifndef FFT_DATA_WIDTH
`define FFT_DATA_WIDTH 16
`endif

package pe_pair_feeder_pkg;

  localparam int FFT_DATA_WIDTH = `FFT_DATA_WIDTH;

  typedef struct packed {
    logic signed [FFT_DATA_WIDTH-1:0] re;
    logic signed [FFT_DATA_WIDTH-1:0] im;
  } FFT_DATA_SAMPLE;

  typedef struct packed {
    logic           valid;
    FFT_DATA_SAMPLE data;
  } FFT_DATA_BUS;

  typedef enum logic {FEED_IDLE, FEED_DOWN} feed_state_t;

  function automatic FFT_DATA_BUS make_valid(input FFT_DATA_SAMPLE s);
    FFT_DATA_BUS b;
    b.valid = 1'b1;
    b.data  = s;
    return b;
  endfunction

endpackage

// File: rtl/feeder_fifo.sv
// Sample FIFO for the pair feeder: synchronous active-high reset, registered occupancy count.
// Push is ignored when full and pop when empty; head_dat_o shows the oldest entry.
module feeder_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_dat_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_dat_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o     = (count_q == (AW+1)'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign head_dat_o = mem_q[rd_ptr_q];

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
    else if (!push_ok && pop_ok) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read once the count says they were written.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/pe_pair_feeder.sv
// Buffers stage samples and issues them to a butterfly PE as atomic (up, down) pairs, 1 cycle pop->pe_out.
// A pair starts only when enable, inter_ready and >=2 buffered samples; src_ready drops when the FIFO is full.
module pe_pair_feeder
  import pe_pair_feeder_pkg::*;
#(
  parameter int DEPTH           = 8,
  parameter int PAIRS_PER_FRAME = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  FFT_DATA_BUS src_in,
  output logic        src_ready,
  input  logic        enable,
  input  logic        inter_ready,
  output FFT_DATA_BUS pe_out,
  output logic        frame_done,
  output logic        overflow
);

  localparam int CW  = $clog2(DEPTH) + 1;
  localparam int PCW = (PAIRS_PER_FRAME > 1) ? $clog2(PAIRS_PER_FRAME) : 1;

  feed_state_t    state_q, state_d;
  logic           chain_q, chain_d;
  FFT_DATA_BUS    pe_out_q, pe_out_d;
  logic [PCW-1:0] pair_cnt_q, pair_cnt_d;
  logic           frame_done_q, frame_done_d;
  logic           overflow_q, overflow_d;

  logic [CW-1:0]  count;
  logic           full, empty, push, pop;
  logic           start_ok, chain_ok;
  FFT_DATA_SAMPLE head;

  feeder_fifo #(
    .WIDTH ($bits(FFT_DATA_SAMPLE)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i      (clk),
    .rst_i      (rst),
    .push_i     (push),
    .push_dat_i (src_in.data),
    .pop_i      (pop),
    .head_dat_o (head),
    .count_o    (count),
    .full_o     (full),
    .empty_o    (empty)
  );

  assign src_ready = !full;
  assign push      = src_in.valid && !full;

  // Start decisions use the registered count, so a same-cycle push never completes a pair.
  // chain_ok looks one pop ahead: the down being popped now leaves count-1 entries.
  assign start_ok = enable && inter_ready && (count >= CW'(2));
  assign chain_ok = enable && inter_ready && (count >= CW'(3));

  always_comb begin
    state_d      = state_q;
    chain_d      = 1'b0;
    pop          = 1'b0;
    pe_out_d     = '0;
    pair_cnt_d   = pair_cnt_q;
    frame_done_d = 1'b0;
    overflow_d   = overflow_q | (src_in.valid && full);
    case (state_q)
      FEED_IDLE: begin
        if (chain_q || start_ok) begin
          pop      = 1'b1;
          pe_out_d = make_valid(head);
          state_d  = FEED_DOWN;
        end
      end
      FEED_DOWN: begin
        // The down is committed once the up went out; inter_ready/enable only gate the next pair.
        pop      = !empty;
        pe_out_d = make_valid(head);
        chain_d  = chain_ok;
        state_d  = FEED_IDLE;
        if (pair_cnt_q == PCW'(PAIRS_PER_FRAME - 1)) begin
          pair_cnt_d   = '0;
          frame_done_d = 1'b1;
        end else begin
          pair_cnt_d = pair_cnt_q + 1'b1;
        end
      end
      default: state_d = FEED_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FEED_IDLE;
      chain_q      <= 1'b0;
      pe_out_q     <= '0;
      pair_cnt_q   <= '0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      chain_q      <= chain_d;
      pe_out_q     <= pe_out_d;
      pair_cnt_q   <= pair_cnt_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
    end
  end

  assign pe_out     = pe_out_q;
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_pe_pair_feeder.sv
// Directed bench for pe_pair_feeder: expected samples queued at push time, popped by an output monitor.
module tb_pe_pair_feeder;
  import pe_pair_feeder_pkg::*;

  localparam int SAMPLES_PER_FRAME = 8;

  logic        clk = 1'b0;
  logic        rst;
  FFT_DATA_BUS src_in;
  logic        src_ready;
  logic        enable;
  logic        inter_ready;
  FFT_DATA_BUS pe_out;
  logic        frame_done;
  logic        overflow;

  always #5 clk = ~clk;

  pe_pair_feeder #(
    .DEPTH           (8),
    .PAIRS_PER_FRAME (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .src_in      (src_in),
    .src_ready   (src_ready),
    .enable      (enable),
    .inter_ready (inter_ready),
    .pe_out      (pe_out),
    .frame_done  (frame_done),
    .overflow    (overflow)
  );

  typedef struct {
    FFT_DATA_SAMPLE s;
    logic           fd;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   errors  = 0;
  int   checks  = 0;
  int   out_cnt = 0;
  int   nsent   = 0;
  bit   mon_en  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Output monitor: every valid beat must match the oldest expected sample and its frame_done flag.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (pe_out.valid === 1'b1) begin
        out_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got %0h with no sample pending", pe_out.data);
        end else begin
          mon_e = exp_q.pop_front();
          check("pe_data", pe_out.data, mon_e.s);
          check("frame_done", frame_done, mon_e.fd);
        end
      end else begin
        check("frame_done_idle", frame_done, 1'b0);
      end
    end
  end

  task automatic push(input logic [15:0] re, input logic [15:0] im, input bit accepted);
    exp_t e;
    src_in.valid   = 1'b1;
    src_in.data.re = re;
    src_in.data.im = im;
    if (accepted) begin
      e.s  = src_in.data;
      e.fd = ((nsent % SAMPLES_PER_FRAME) == SAMPLES_PER_FRAME - 1);
      exp_q.push_back(e);
      nsent++;
    end
    @(posedge clk);
    #1 src_in.valid = 1'b0;
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    src_in.valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    nsent = 0;
  endtask

  task automatic push_block(input int n, input logic [15:0] tag);
    for (int i = 0; i < n; i++) push(tag + 16'(i * 16), tag + 16'(i * 16 + 1), 1'b1);
  endtask

  task automatic wait_first_valid(input string name);
    int t = 0;
    while (pe_out.valid !== 1'b1 && t < 10) begin
      @(negedge clk);
      t++;
    end
    if (t == 10) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no valid output, required one within 10 cycles", name);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, required finish before 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst          = 1'b1;
    src_in       = '0;
    enable       = 1'b1;
    inter_ready  = 1'b1;

    // 1: reset held for 3 cycles while a sample is offered
    src_in.valid   = 1'b1;
    src_in.data.re = 16'sd7;
    src_in.data.im = 16'sd7;
    repeat (3) begin
      @(negedge clk);
    end
    check("rst_valid", pe_out.valid, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_frame_done", frame_done, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    src_in.valid = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    check("rst_src_ready", src_ready, 1'b1);
    check("rst_no_out", pe_out.valid, 1'b0);

    // 2: single sample waits; second completes the pair, up 1 cycle after its pop
    push(16'd1, 16'd2, 1'b1);
    repeat (3) @(negedge clk);
    check("single_no_out", 64'(out_cnt), 64'd0);
    push(16'd3, 16'd4, 1'b1);
    @(negedge clk);
    check("lat_pre", pe_out.valid, 1'b0);
    @(negedge clk);
    check("lat_up", pe_out.valid, 1'b1);
    repeat (3) @(negedge clk);
    check("pair_count", 64'(out_cnt), 64'd2);

    // 3: inter_ready dropped while the up is on pe_out; down still follows
    inter_ready = 1'b0;
    push_block(4, 16'h0100);
    base = out_cnt;
    inter_ready = 1'b1;
    @(posedge clk);
    #1 inter_ready = 1'b0;
    repeat (5) @(negedge clk);
    check("atomic_pair", 64'(out_cnt - base), 64'd2);
    check("atomic_hold", pe_out.valid, 1'b0);
    inter_ready = 1'b1;
    repeat (5) @(negedge clk);
    check("atomic_resume", 64'(out_cnt - base), 64'd4);

    // 4: a full frame streams 8 back-to-back beats, frame_done on the last
    do_reset();
    inter_ready = 1'b0;
    push_block(8, 16'h0200);
    inter_ready = 1'b1;
    @(negedge clk);
    wait_first_valid("stream");
    for (int k = 0; k < 8; k++) begin
      check("stream_valid", pe_out.valid, 1'b1);
      @(negedge clk);
    end
    check("stream_end", pe_out.valid, 1'b0);

    // 5: ninth sample into a full FIFO is dropped and overflow sticks
    do_reset();
    inter_ready = 1'b0;
    @(negedge clk);
    check("ovf_ready_pre", src_ready, 1'b1);
    push_block(8, 16'h0300);
    @(negedge clk);
    check("ovf_ready_full", src_ready, 1'b0);
    check("ovf_pre", overflow, 1'b0);
    base = out_cnt;
    push(16'hDEAD, 16'hBEEF, 1'b0);
    @(negedge clk);
    check("ovf_set", overflow, 1'b1);
    inter_ready = 1'b1;
    repeat (12) @(negedge clk);
    check("ovf_drain", 64'(out_cnt - base), 64'd8);
    check("ovf_sticky", overflow, 1'b1);
    check("ovf_ready_post", src_ready, 1'b1);

    // 6: enable dropped mid-stream stops at the pair boundary
    do_reset();
    check("rst_clears_ovf", overflow, 1'b0);
    inter_ready = 1'b0;
    push_block(8, 16'h0400);
    base = out_cnt;
    inter_ready = 1'b1;
    @(negedge clk);
    wait_first_valid("enable");
    enable = 1'b0;
    repeat (6) @(negedge clk);
    check("enable_pair_done", 64'(out_cnt - base), 64'd2);
    check("enable_hold", pe_out.valid, 1'b0);
    enable = 1'b1;
    repeat (10) @(negedge clk);
    check("enable_resume", 64'(out_cnt - base), 64'd8);
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
